// File: rtl/karatsuba_recombine_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba_recombine_serial_if
// Brief    : Handshake and data bundle for one Karatsuba recombine level.
//            The slave side is the recombiner and the master side is the
//            producer/consumer pair around it.
// Revision : 1.0 - initial release
// ============================================================================
interface karatsuba_recombine_serial_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   pp_hi;
    logic [N-1:0]   pp_lo;
    logic [N+1:0]   pp_mid;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           err;
    logic           ovf;
    logic           busy;

    modport slave (
        input  in_valid, pp_hi, pp_lo, pp_mid, out_ready,
        output in_ready, out_valid, product, err, ovf, busy
    );

    modport master (
        output in_valid, pp_hi, pp_lo, pp_mid, out_ready,
        input  in_ready, out_valid, product, err, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/karatsuba_recombine_serial.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba_recombine_serial
// Brief    : Digit-serial Karatsuba recombination
//            product = (hi << N) + ((mid - hi - lo) << N/2) + lo
//            using a 5-input column counter (three operands plus two carry
//            chains), DIGIT columns per clock, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module karatsuba_recombine_serial #(
    parameter int N     = 32,
    parameter int DIGIT = 8
) (
    input wire clk,
    input wire rst_n,
    karatsuba_recombine_serial_if.slave bus
);

    localparam int c_H  = N / 2;
    localparam int c_W  = 2 * N;
    localparam int NCYC = c_W / DIGIT;
    localparam int c_CW = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NCYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Operand shift registers: the current digit always sits in the low bits.
    logic [c_W-1:0]  r_g1;
    logic [c_W-1:0]  r_g2;
    logic [c_W-1:0]  r_g3;
    logic [N+1:0]    r_mid;
    logic            r_ca;
    logic            r_cb;
    logic [c_CW-1:0] r_cnt;
    logic [c_W-1:0]  r_product;
    logic            r_err;
    logic            r_ovf;
    logic            r_out_valid;

    // Middle term m = mid - hi - lo; one extra bit above mid holds the sign.
    logic [N+2:0]    w_m;
    logic            w_neg;
    logic            w_unused_m;
    logic [c_W-1:0]  w_g2_load;

    // Column counter chain for one digit.
    logic [DIGIT:0]   w_ca;
    logic [DIGIT:0]   w_cb;
    logic [DIGIT-1:0] w_sum;
    logic [c_W-1:0]   w_sum_ext;
    logic [c_W-1:0]   w_product_shift;

    // hi sits in the top half of g1 and lo in the bottom half of g3 after capture.
    assign w_m   = {1'b0, r_mid} - {3'b000, r_g1[c_W-1:N]} - {3'b000, r_g3[N-1:0]};
    assign w_neg = w_m[N+2];
    // For genuine Karatsuba inputs m < 2^(N+1); only m[N:0] is weighted in.
    assign w_unused_m = w_m[N+1];

    // Place m[N:0] at the half-split offset inside a 2N-bit operand.
    always_comb begin
        w_g2_load = '0;
        w_g2_load[c_H +: N+1] = w_m[N:0];
    end

    assign w_ca[0] = r_ca;
    assign w_cb[0] = r_cb;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_col
            logic [2:0] w_cnt;
            assign w_cnt = {2'b00, r_g1[i]} + {2'b00, r_g2[i]} + {2'b00, r_g3[i]}
                         + {2'b00, w_ca[i]} + {2'b00, w_cb[i]};
            assign w_sum[i]  = w_cnt[0];
            // Both carries carry weight 2 into the next column: cnt = sum + 2*(ca+cb).
            assign w_ca[i+1] = (w_cnt >= 3'd2);
            assign w_cb[i+1] = (w_cnt >= 3'd4);
        end
    endgenerate

    // Sum digits enter at the top so the first digit ends at bit 0 after NCYC shifts.
    always_comb begin
        w_sum_ext = '0;
        w_sum_ext[DIGIT-1:0] = w_sum;
        w_product_shift = (r_product >> DIGIT) | (w_sum_ext << (c_W - DIGIT));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_state_next = S_LOAD;
            S_LOAD: w_state_next = w_neg ? S_DONE : S_RUN;
            S_RUN:  if (r_cnt == c_LAST) w_state_next = S_DONE;
            S_DONE: if (r_out_valid && bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, digit-serial compression and result holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g1        <= '0;
            r_g2        <= '0;
            r_g3        <= '0;
            r_mid       <= '0;
            r_ca        <= 1'b0;
            r_cb        <= 1'b0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_g1  <= {bus.pp_hi, {N{1'b0}}};
                        r_g3  <= {{N{1'b0}}, bus.pp_lo};
                        r_mid <= bus.pp_mid;
                    end
                end
                S_LOAD: begin
                    r_ca      <= 1'b0;
                    r_cb      <= 1'b0;
                    r_cnt     <= '0;
                    r_product <= '0;
                    r_ovf     <= 1'b0;
                    r_err     <= w_neg;
                    r_g2      <= w_g2_load;
                end
                S_RUN: begin
                    r_g1      <= r_g1 >> DIGIT;
                    r_g2      <= r_g2 >> DIGIT;
                    r_g3      <= r_g3 >> DIGIT;
                    r_ca      <= w_ca[DIGIT];
                    r_cb      <= w_cb[DIGIT];
                    r_product <= w_product_shift;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_ovf       <= w_ca[DIGIT] | w_cb[DIGIT];
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    // The reject path arrives with out_valid low and spends one
                    // settling cycle here, presenting two edges after capture.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign bus.err       = r_err;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_recombine_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_karatsuba_recombine_serial
// Brief    : Scoreboard bench for the digit-serial Karatsuba recombiner
//            (N=8, DIGIT=4): directed vectors, backpressure, mid-run reset
//            and randomized partial products against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_karatsuba_recombine_serial;

    localparam int N     = 8;
    localparam int DIGIT = 4;
    localparam int H     = N / 2;
    localparam int W     = 2 * N;
    localparam int NCYC  = W / DIGIT;

    typedef struct {
        logic [W-1:0] p;
        bit           e;
        bit           o;
        longint       lat;
        longint       t0;
    } exp_t;

    logic   clk;
    logic   rst_n;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     stall_left = 0;
    bit     rand_mode = 0;
    exp_t   sb[$];

    karatsuba_recombine_serial_if #(.N(N)) bus ();

    karatsuba_recombine_serial #(.N(N), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Reference: plain integer arithmetic on the recombination formula.
    function automatic exp_t model(input longint hi, input longint lo, input longint mid);
        exp_t   x;
        longint m;
        longint tot;
        m = mid - hi - lo;
        x.t0 = 0;
        if (m < 0) begin
            x.p   = '0;
            x.e   = 1'b1;
            x.o   = 1'b0;
            x.lat = 2;
        end else begin
            m     = m % (longint'(1) << (N + 1));
            tot   = (hi << N) + (m << H) + lo;
            x.p   = tot[W-1:0];
            x.e   = 1'b0;
            x.o   = ((tot >> W) != 0);
            x.lat = 1 + NCYC;
        end
        return x;
    endfunction

    task automatic send(input logic [N-1:0] hi, input logic [N-1:0] lo,
                        input logic [N+1:0] mid, input bit track);
        exp_t x;
        int   waited;
        x = model(longint'(hi), longint'(lo), longint'(mid));
        bus.in_valid = 1'b1;
        bus.pp_hi    = hi;
        bus.pp_lo    = lo;
        bus.pp_mid   = mid;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 300) begin
                timeout_fail("in_ready_wait");
                break;
            end
        end
        x.t0 = cyc + 1;
        @(posedge clk);
        if (track) sb.push_back(x);
        #1;
        bus.in_valid = 1'b0;
        bus.pp_hi    = N'($urandom);
        bus.pp_lo    = N'($urandom);
        bus.pp_mid   = (N+2)'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || bus.out_valid) && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (w >= 500) timeout_fail("drain");
        #1;
    endtask

    // Consumer: optional directed stall, otherwise always-ready or random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                if (bus.out_valid) stall_left--;
            end else if (rand_mode) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: latency on rising out_valid, result on handshake, hold rules.
    initial begin
        bit           pv;
        bit           pr;
        logic [W-1:0] pp;
        bit           pe;
        bit           po;
        exp_t         x;
        pv = 0; pr = 0; pp = '0; pe = 0; po = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
                pr = 0;
                continue;
            end
            if (pv && !pr) begin
                chk("hold_out_valid", longint'(bus.out_valid), 1);
                chk("hold_product",   longint'(bus.product), longint'(pp));
                chk("hold_err",       longint'(bus.err), longint'(pe));
                chk("hold_ovf",       longint'(bus.ovf), longint'(po));
                chk("hold_in_ready",  longint'(bus.in_ready), 0);
            end
            if (pv && pr) begin
                chk("in_ready_after_hs",  longint'(bus.in_ready), 1);
                chk("out_valid_after_hs", longint'(bus.out_valid), 0);
            end
            if (bus.out_valid && !pv) begin
                chk("expected_result_pending", longint'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("latency", cyc - sb[0].t0, sb[0].lat);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("scoreboard_nonempty", longint'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    chk("product", longint'(bus.product), longint'(x.p));
                    chk("err",     longint'(bus.err), longint'(x.e));
                    chk("ovf",     longint'(bus.ovf), longint'(x.o));
                end
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pp = bus.product;
            pe = bus.err;
            po = bus.ovf;
        end
    end

    // Stimulus.
    initial begin
        int unsigned ah, al, bh, bl;
        logic [N-1:0] hi, lo;
        logic [N+1:0] mid;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.pp_hi    = '0;
        bus.pp_lo    = '0;
        bus.pp_mid   = '0;
        #1;
        chk("rst_in_ready",  longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_product",   longint'(bus.product), 0);
        chk("rst_err",       longint'(bus.err), 0);
        chk("rst_ovf",       longint'(bus.ovf), 0);
        chk("rst_busy",      longint'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors.
        send(8'd120, 8'd15,  10'd225, 1);   // 0xC3*0xA5 = 0x7DAF
        send(8'd225, 8'd225, 10'd900, 1);   // 0xFF*0xFF = 0xFE01
        send(8'd10,  8'd10,  10'd5,   1);   // negative middle term
        send(8'd255, 8'd0,   10'd766, 1);   // 0x1EF0 with overflow
        drain();

        // Backpressure then back-to-back.
        stall_left = 5;
        send(8'd120, 8'd15, 10'd225, 1);
        send(8'd56,  8'd12, 10'd150, 1);
        drain();

        // Reset during the third RUN cycle.
        send(8'd225, 8'd225, 10'd900, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_in_run", longint'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  longint'(bus.in_ready), 1);
        chk("abort_out_valid", longint'(bus.out_valid), 0);
        chk("abort_product",   longint'(bus.product), 0);
        chk("abort_err",       longint'(bus.err), 0);
        chk("abort_ovf",       longint'(bus.ovf), 0);
        chk("abort_busy",      longint'(bus.busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd225, 8'd225, 10'd900, 1);
        drain();

        // Randomized partial products with a random consumer.
        rand_mode = 1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ah = $urandom_range(0, 15); al = $urandom_range(0, 15);
                    bh = $urandom_range(0, 15); bl = $urandom_range(0, 15);
                    hi  = N'(ah * bh);
                    lo  = N'(al * bl);
                    mid = (N+2)'((ah + al) * (bh + bl));
                end
                1: begin
                    hi  = N'($urandom);
                    lo  = N'($urandom);
                    mid = (N+2)'($urandom);
                end
                default: begin
                    hi  = N'($urandom);
                    lo  = N'($urandom);
                    mid = (N+2)'(int'(hi) + int'(lo) + int'($urandom_range(0, 511)));
                end
            endcase
            send(hi, lo, mid, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/karatsuba_recombine_serial.md
Name: karatsuba_recombine_serial

Overview:
Parametrised, digit-serial successor to the one-shot composite multi-operand adders. It takes the three Karatsuba partial products of one N-bit level (hi, lo, mid) and forms product = (hi << N) + ((mid - hi - lo) << N/2) + lo. The sum is computed with the same 5-input column counter (3 operands + 2 carry chains), processing DIGIT columns per clock. It sits at the output of each Karatsuba level, with a valid/ready handshake on both sides, so that levels can be chained or pipelined.

Parameters:
N, 32, operand width of this level; must be even (half-split H = N/2)
DIGIT, 8, columns compressed per clock; must divide 2N
NCYC, 2N/DIGIT, derived localparam: number of RUN cycles

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  partial products presented
in_ready  output  1  block can accept (high only in IDLE)
pp_hi  input  N  high-half product (a_hi*b_hi)
pp_lo  input  N  low-half product (a_lo*b_lo)
pp_mid  input  N+2  cross product ((a_hi+a_lo)*(b_hi+b_lo))
out_valid  output  1  result held stable
out_ready  input  1  consumer accepts result
product  output  2N  recombined result (low 2N bits)
err  output  1  mid - hi - lo was negative
ovf  output  1  nonzero carry out of column 2N-1
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; product=0; err=0; ovf=0; busy=0; carry regs, counters and operand shift registers cleared. Reset asserted mid-RUN or mid-DONE aborts immediately and discards the result.
- FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready at edge T0: capture pp_hi, pp_lo, pp_mid; go to LOAD.
- LOAD (1 cycle): m = pp_mid - pp_hi - pp_lo, computed at N+3 bits.
  - If negative: err=1, product=0, ovf=0; go directly to DONE.
  - Otherwise: load 2N-bit operands g1 = hi<<N, g2 = m[N:0]<<H, g3 = lo; clear carries ca=cb=0 and the digit counter; go to RUN.
- RUN (exactly NCYC cycles): each cycle compresses columns j = k*DIGIT .. k*DIGIT+DIGIT-1, LSB first, rippling within the cycle.
  - Column rule: cnt = g1[j] + g2[j] + g3[j] + ca + cb (0..5).
  - sum[j] = cnt[0]; ca_next = (cnt>=2); cb_next = (cnt>=4). Both carries have weight 2 into column j+1.
  - Carries after the last column of a digit are registered into the next cycle.
  - Sum digits shift into the product register.
- After the final digit: ovf = ca|cb; go to DONE.
- DONE: out_valid=1; product, err and ovf are held stable. On out_valid&out_ready: out_valid=0, go to IDLE. in_ready returns to 1 on the cycle after the handshake; there is no same-cycle accept in DONE.
- Latency: out_valid asserts after edge T0+1+NCYC (9 edges at N=32, DIGIT=8). The err path asserts after edge T0+2.
- Throughput: one result per NCYC+3 cycles, assuming out_ready is high.
- in_valid is ignored outside IDLE. Input values outside IDLE do not affect an operation in flight.
- product, err and ovf are valid only while out_valid=1. They keep their last value after the handshake until the next LOAD.

Test Plan:
- N=8, DIGIT=4, operands a=0xC3, b=0xA5: pp_hi=120, pp_lo=15, pp_mid=225 -> product=32175 (0x7DAF), err=0, ovf=0, out_valid after edge T0+5.
- N=8, DIGIT=1, a=b=0xFF: pp_hi=225, pp_lo=225, pp_mid=900 -> product=0xFE01, ovf=0, out_valid after edge T0+17. Repeat with DIGIT=16 -> same result after edge T0+2.
- N=8: pp_hi=10, pp_lo=10, pp_mid=5 -> err=1, product=0, ovf=0, out_valid after edge T0+2, RUN skipped.
- N=8: pp_hi=255, pp_lo=0, pp_mid=766 (m=511) -> product=0x1EF0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0. Raise out_ready -> one handshake, then in_ready=1 next cycle. Back-to-back second operation returns the correct independent result.
- Pull rst_n low for 1 cycle during the 3rd RUN cycle -> all outputs at reset values immediately and in_ready=1. A fresh transaction afterwards gives the correct product, with no stale carry.
